// File: rtl/lockreg_pkg.sv
// Shared definitions for the locked-register write controller.
// Holds the FSM state encoding, FIFO geometry, counter width, the queued
// request payload and a saturating-increment helper.
package lockreg_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic              debug;
        logic [DATA_W-1:0] data;
    } req_entry_t;

    localparam int unsigned ENTRY_W = $bits(req_entry_t);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lockreg_req_fifo.sv
// Request FIFO, FIFO_DEPTH entries of req_entry_t, show-ahead read.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/wdata_i write one entry (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   rdata_o        current head entry
//   full_o/empty_o occupancy flags, count_o current occupancy
module lockreg_req_fifo
    import lockreg_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  req_entry_t            wdata_i,
    input  logic                  pop_i,
    output req_entry_t            rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    req_entry_t            mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_push_c;
    logic                  do_pop_c;

    assign full_o    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_c = push_i && !full_o;
    assign do_pop_c  = pop_i && !empty_o;

    // Storage, pointers and occupancy; pointers wrap naturally at depth 4.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            count_q <= count_q + FIFO_CNT_W'(do_push_c) - FIFO_CNT_W'(do_pop_c);
        end
    end

endmodule

// File: rtl/locked_reg_write_ctrl.sv
// Write controller in front of a lockable register.
// Requests are queued, then issued or dropped one per cycle depending on the
// lock state and the debug qualifiers present on the pop edge. A lock request
// drains the queue before the register lock is asserted for good.
// Ports:
//   Clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_data, req_debug            request payload and debug flag
//   lock_req                       lock request pulse
//   trusted, debug_mode            debug-write qualifiers
//   reg_data, reg_write, reg_lock  locked register interface
//   err_reject, reject_cnt         sticky drop flag and saturating drop count
module locked_reg_write_ctrl
    import lockreg_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_debug,
    input  logic              lock_req,
    input  logic              trusted,
    input  logic              debug_mode,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_write,
    output logic              reg_lock,
    output logic              err_reject,
    output logic [CNT_W-1:0]  reject_cnt
);

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     reg_data_q, reg_data_d;
    logic                  reg_write_q, reg_write_d;
    logic                  reg_lock_q, reg_lock_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic                  push_c;
    logic                  pop_c;
    logic                  issue_c;
    logic                  drop_c;
    logic [FIFO_CNT_W-1:0] occ_c;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    req_entry_t            head;
    req_entry_t            push_entry;

    assign push_entry = req_entry_t'({req_debug, req_data});
    assign push_c     = req_valid && ready_q && !fifo_full;
    assign pop_c      = !fifo_empty;

    lockreg_req_fifo u_fifo (
        .clk_i   (Clk),
        .rst_i   (reset),
        .push_i  (push_c),
        .wdata_i (push_entry),
        .pop_i   (pop_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State and output registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OPEN;
            reg_data_q  <= '0;
            reg_write_q <= 1'b0;
            reg_lock_q  <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            reg_data_q  <= reg_data_d;
            reg_write_q <= reg_write_d;
            reg_lock_q  <= reg_lock_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
        end
    end

    // Next state, issue/drop decision and next output values.
    always_comb begin
        state_d     = state_q;
        reg_data_d  = reg_data_q;
        reg_write_d = 1'b0;
        reg_lock_d  = reg_lock_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        issue_c     = 1'b0;
        drop_c      = 1'b0;
        occ_c       = fifo_count + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);

        // Debug writes depend only on the qualifiers; normal writes on the lock.
        if (pop_c) begin
            if (head.debug) begin
                issue_c = debug_mode && trusted;
            end else begin
                issue_c = (state_q != ST_LOCKED);
            end
            drop_c = !issue_c;
        end

        // DRAIN leaves on the first edge that finds the queue already empty.
        case (state_q)
            ST_OPEN:   if (lock_req)   state_d = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty) state_d = ST_LOCKED;
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_OPEN;
        endcase

        if (issue_c) begin
            reg_data_d  = head.data;
            reg_write_d = 1'b1;
        end
        if (drop_c) begin
            err_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
        end
        if (state_d == ST_LOCKED) begin
            reg_lock_d = 1'b1;
        end

        // Ready reflects post-edge occupancy, so a full FIFO is never bypassed.
        ready_d = (occ_c != FIFO_CNT_W'(FIFO_DEPTH)) && (state_d != ST_DRAIN);
    end

    assign req_ready  = ready_q;
    assign reg_data   = reg_data_q;
    assign reg_write  = reg_write_q;
    assign reg_lock   = reg_lock_q;
    assign err_reject = err_q;
    assign reject_cnt = cnt_q;

endmodule

// File: tb/tb_locked_reg_write_ctrl.sv
// Self-checking bench for locked_reg_write_ctrl: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// queue-based reference model.
module tb_locked_reg_write_ctrl;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_debug, lock_req, trusted, debug_mode;
    logic [15:0] req_data, reg_data;
    logic        reg_write, reg_lock, err_reject;
    logic [7:0]  reject_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    locked_reg_write_ctrl dut (
        .Clk        (Clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_debug  (req_debug),
        .lock_req   (lock_req),
        .trusted    (trusted),
        .debug_mode (debug_mode),
        .reg_data   (reg_data),
        .reg_write  (reg_write),
        .reg_lock   (reg_lock),
        .err_reject (err_reject),
        .reject_cnt (reject_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed { bit dbg; logic [15:0] data; } ent_t;
    ent_t        mq[$];
    bit          m_locked, m_drain, m_ready, m_write, m_lock, m_err;
    logic [15:0] m_data;
    int          m_cnt;

    function automatic void model_reset();
        mq.delete();
        m_locked = 0; m_drain = 0; m_ready = 1; m_write = 0; m_lock = 0; m_err = 0;
        m_data = 16'h0000; m_cnt = 0;
    endfunction

    // Effect of one rising edge given the inputs currently driven.
    function automatic void model_edge();
        bit   was_empty, hs, ok;
        ent_t e;
        was_empty = (mq.size() == 0);
        hs        = req_valid && m_ready;
        m_write   = 0;
        if (!was_empty) begin
            e  = mq.pop_front();
            ok = e.dbg ? (debug_mode && trusted) : !m_locked;
            if (ok) begin
                m_write = 1;
                m_data  = e.data;
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (m_drain && was_empty) begin
            m_drain  = 0;
            m_locked = 1;
        end else if (!m_drain && !m_locked && lock_req) begin
            m_drain = 1;
        end
        if (hs) mq.push_back('{dbg: req_debug, data: req_data});
        m_lock  = m_locked;
        m_ready = (mq.size() < 4) && !m_drain;
    endfunction

    // ---------------- helpers ----------------
    task automatic check_out(input string name, input bit ew, input logic [15:0] ed,
                             input bit er, input bit el, input bit ee, input logic [7:0] ec);
        n_cmp++;
        if (reg_write !== ew || reg_data !== ed || req_ready !== er ||
            reg_lock !== el || err_reject !== ee || reject_cnt !== ec) begin
            n_fail++;
            $display("FAIL %s @%0t: got w=%0b d=%h rdy=%0b lk=%0b err=%0b cnt=%0d, expected w=%0b d=%h rdy=%0b lk=%0b err=%0b cnt=%0d",
                     name, $time, reg_write, reg_data, req_ready, reg_lock, err_reject, reject_cnt,
                     ew, ed, er, el, ee, ec);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit dbg,
                         input bit lk, input bit tr, input bit dm);
        req_valid = v; req_data = d; req_debug = dbg;
        lock_req = lk; trusted = tr; debug_mode = dm;
    endtask

    task automatic drive_idle();
        drive(0, 16'h0000, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle, check async clear, release mid-cycle.
    task automatic do_reset();
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        check_out("reset_async", 0, 16'h0000, 1, 0, 0, 8'h00);
        repeat (2) @(posedge Clk);
        #1;
        check_out("reset_hold", 0, 16'h0000, 1, 0, 0, 8'h00);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic model_step(input string name);
        model_edge();
        @(posedge Clk);
        #1;
        check_out(name, m_write, m_data, m_ready, m_lock, m_err, 8'(m_cnt));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v; logic [15:0] d; bit dbg, lk, tr, dm;
        bit ew; logic [15:0] ed; bit er, el, ee; logic [7:0] ec;
    } vec_t;
    vec_t tbl[16];

    logic [15:0] seen[$];
    logic [15:0] exp5[5];

    initial begin
        drive_idle();
        //        v  data     dbg lk tr dm | w  data     rdy lk err cnt
        tbl[0]  = '{1, 16'h1111, 0, 0, 0, 0,  0, 16'h0000, 1, 0, 0, 8'd0};
        tbl[1]  = '{1, 16'h2222, 0, 0, 0, 0,  1, 16'h1111, 1, 0, 0, 8'd0};
        tbl[2]  = '{1, 16'h3333, 0, 0, 0, 0,  1, 16'h2222, 1, 0, 0, 8'd0};
        tbl[3]  = '{0, 16'h0000, 0, 0, 0, 0,  1, 16'h3333, 1, 0, 0, 8'd0};
        tbl[4]  = '{0, 16'h0000, 0, 0, 0, 0,  0, 16'h3333, 1, 0, 0, 8'd0};
        tbl[5]  = '{1, 16'h4444, 0, 0, 0, 0,  0, 16'h3333, 1, 0, 0, 8'd0};
        tbl[6]  = '{1, 16'h5555, 0, 1, 0, 0,  1, 16'h4444, 0, 0, 0, 8'd0};
        tbl[7]  = '{1, 16'h6666, 0, 0, 0, 0,  1, 16'h5555, 0, 0, 0, 8'd0};
        tbl[8]  = '{1, 16'h6666, 0, 0, 0, 0,  0, 16'h5555, 1, 1, 0, 8'd0};
        tbl[9]  = '{1, 16'hBEEF, 0, 0, 0, 0,  0, 16'h5555, 1, 1, 0, 8'd0};
        tbl[10] = '{0, 16'h0000, 0, 0, 0, 0,  0, 16'h5555, 1, 1, 1, 8'd1};
        tbl[11] = '{1, 16'hD00D, 1, 0, 1, 1,  0, 16'h5555, 1, 1, 1, 8'd1};
        tbl[12] = '{0, 16'h0000, 0, 0, 0, 1,  0, 16'h5555, 1, 1, 1, 8'd2};
        tbl[13] = '{1, 16'hD00D, 1, 0, 0, 1,  0, 16'h5555, 1, 1, 1, 8'd2};
        tbl[14] = '{0, 16'h0000, 0, 0, 1, 1,  1, 16'hD00D, 1, 1, 1, 8'd2};
        tbl[15] = '{0, 16'h0000, 0, 1, 0, 0,  0, 16'hD00D, 1, 1, 1, 8'd2};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].dbg, tbl[i].lk, tbl[i].tr, tbl[i].dm);
            @(posedge Clk);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].ew, tbl[i].ed, tbl[i].er,
                      tbl[i].el, tbl[i].ee, tbl[i].ec);
        end

        // Five writes with a one-cycle gap: strobes must come out once each, in order.
        do_reset();
        seen.delete();
        exp5[0] = 16'hA001; exp5[1] = 16'hA002; exp5[2] = 16'hA003;
        exp5[3] = 16'hA004; exp5[4] = 16'hA005;
        for (int i = 0; i < 10; i++) begin
            if (i < 2)                drive(1, exp5[i], 0, 0, 0, 0);
            else if (i >= 3 && i < 6) drive(1, exp5[i-1], 0, 0, 0, 0);
            else                      drive_idle();
            model_step("five_writes");
            if (reg_write === 1'b1) seen.push_back(reg_data);
        end
        n_cmp++;
        if (seen.size() != 5 || seen[0] !== exp5[0] || seen[1] !== exp5[1] ||
            seen[2] !== exp5[2] || seen[3] !== exp5[3] || seen[4] !== exp5[4]) begin
            n_fail++;
            $display("FAIL five_writes_order: got %0d strobes, expected 5 (A001..A005 in order)",
                     seen.size());
        end

        // Saturation: 260 rejected writes in LOCKED.
        do_reset();
        drive(0, 16'h0000, 0, 1, 0, 0);
        model_step("sat_lock");
        drive_idle();
        model_step("sat_locked");
        for (int i = 0; i < 260; i++) begin
            drive(1, 16'($urandom), 0, 0, 0, 0);
            model_step("sat_loop");
        end
        drive_idle();
        model_step("sat_tail");
        n_cmp++;
        if (reject_cnt !== 8'hFF || err_reject !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final: got cnt=%h err=%0b, expected cnt=ff err=1",
                     reject_cnt, err_reject);
        end

        // Reset while draining: queued entry discarded, no strobe after release.
        do_reset();
        drive(1, 16'hC001, 0, 0, 0, 0);
        model_step("drain_rst_push");
        drive(1, 16'hC002, 0, 1, 0, 0);
        model_step("drain_rst_lock");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            model_step("post_reset_quiet");
        end

        // Randomized traffic against the model.
        for (int ep = 0; ep < 3; ep++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0);
                model_step("random");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
